// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg: shared types and constants for the RV32/RV64 immediate decode stage.
//   imm_type_t : immediate format encoding driven on out_type
//   OPC_*      : 7-bit major opcodes
//   decoded_t  : one decoded beat; XLEN fields are sized for the widest datapath
package rv_imm_pkg;

   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {
      IMM_I       = 3'b000,
      IMM_S       = 3'b001,
      IMM_B       = 3'b010,
      IMM_U       = 3'b011,
      IMM_J       = 3'b100,
      IMM_R       = 3'b101,
      IMM_ILLEGAL = 3'b111
   } imm_type_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef struct packed {
      imm_type_t             itype;
      logic [XLEN_MAX-1:0]   imm;
      logic [XLEN_MAX-1:0]   target;
      logic [XLEN_MAX-1:0]   pc;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [6:0]            opcode;
   } decoded_t;

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational opcode-to-format classification and immediate
// extraction, sign-extended to XLEN.
//   insn     in  32    instruction word
//   imm_type out       immediate format (ILLEGAL for unknown opcodes)
//   imm      out XLEN  sign-extended immediate, 0 for R and ILLEGAL
module imm_extract
   import rv_imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     insn,
   output imm_type_t       imm_type,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;
   logic [63:0] imm64;

   // All opcode constants end in 2'b11, so a compressed encoding falls to default.
   always_comb begin
      imm_type = IMM_ILLEGAL;
      case (insn[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR,
         OPC_MISC_MEM, OPC_SYSTEM:  imm_type = IMM_I;
         OPC_STORE:                 imm_type = IMM_S;
         OPC_BRANCH:                imm_type = IMM_B;
         OPC_LUI, OPC_AUIPC:        imm_type = IMM_U;
         OPC_JAL:                   imm_type = IMM_J;
         OPC_OP:                    imm_type = IMM_R;
         OPC_OP_32:                 imm_type = (XLEN == 64) ? IMM_R : IMM_ILLEGAL;
         OPC_OP_IMM_32:             imm_type = (XLEN == 64) ? IMM_I : IMM_ILLEGAL;
         default:                   imm_type = IMM_ILLEGAL;
      endcase
   end

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{insn[31]}}, insn[31:20]};
         IMM_S:   imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         IMM_B:   imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         IMM_U:   imm32 = {insn[31:12], 12'b0};
         IMM_J:   imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      imm64 = {{32{imm32[31]}}, imm32};
      imm   = XLEN'(imm64);
   end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered decode stage between fetch and execute.
// Decodes at the input, then stores the decoded beat in a main entry plus an
// optional skid entry so that in_ready can come straight from a flop.
//   clk, rst                 rising-edge clock, async active-high reset
//   flush                    drop all held entries and the current input beat
//   in_valid/in_ready        input handshake; in_insn, in_pc carry the beat
//   out_valid/out_ready      output handshake
//   out_type, out_imm        immediate format and sign-extended immediate
//   out_target               out_pc + out_imm (mod 2^XLEN)
//   out_pc, out_rd, out_rs1, out_rs2, out_opcode   passed-through fields
module imm_decode_stage #(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_insn,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      out_type,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [6:0]      out_opcode
);

   import rv_imm_pkg::*;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   imm_type_t       in_type;
   logic [XLEN-1:0] in_imm;
   logic [XLEN-1:0] in_target;
   decoded_t        in_dec;

   state_t   state_q, state_d;
   decoded_t main_q, main_d;
   decoded_t skid_q, skid_d;
   logic     push, pop;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .insn     (in_insn),
      .imm_type (in_type),
      .imm      (in_imm)
   );

   assign in_target = in_pc + in_imm;

   always_comb begin
      in_dec.itype  = in_type;
      in_dec.imm    = 64'(in_imm);
      in_dec.target = 64'(in_target);
      in_dec.pc     = 64'(in_pc);
      in_dec.rd     = in_insn[11:7];
      in_dec.rs1    = in_insn[19:15];
      in_dec.rs2    = in_insn[24:20];
      in_dec.opcode = in_insn[6:0];
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign pop       = out_valid && out_ready;
   assign push      = in_valid && in_ready && !flush;

   generate
      if (SKID != 0) begin : g_skid
         // Ready is the registered image of "next state is not full", which
         // keeps out_ready off any combinational path to in_ready.
         logic ready_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) ready_q <= 1'b1;
            else     ready_q <= (state_d != ST_TWO);
         end
         assign in_ready = ready_q;
      end else begin : g_noskid
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_d = ST_ONE;
                  main_d  = in_dec;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_d = in_dec;
               end else if (push && SKID != 0) begin
                  state_d = ST_TWO;
                  skid_d  = in_dec;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_type   = main_q.itype;
   assign out_imm    = XLEN'(main_q.imm);
   assign out_target = XLEN'(main_q.target);
   assign out_pc     = XLEN'(main_q.pc);
   assign out_rd     = main_q.rd;
   assign out_rs1    = main_q.rs1;
   assign out_rs2    = main_q.rs2;
   assign out_opcode = main_q.opcode;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: self-checking bench for imm_decode_stage.
// Two instances: XLEN=32 with skid buffer (index 0) and XLEN=64 without (index 1).
// Directed vector table, hand-written handshake/flush/reset sequences, then
// random traffic against a queue-based reference model.
module tb_imm_decode_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv[2];
   logic        fl[2];
   logic        ordy[2];
   logic [31:0] insn[2];
   logic [63:0] pcv[2];

   logic        ir0, ov0;
   logic [2:0]  ty0;
   logic [31:0] imm0, tgt0, pco0;
   logic [4:0]  rd0, rs10, rs20;
   logic [6:0]  opc0;

   logic        ir1, ov1;
   logic [2:0]  ty1;
   logic [63:0] imm1, tgt1, pco1;
   logic [4:0]  rd1, rs11, rs21;
   logic [6:0]  opc1;

   imm_decode_stage #(.XLEN(32), .SKID(1)) dut32 (
      .clk(clk), .rst(rst), .flush(fl[0]),
      .in_valid(iv[0]), .in_ready(ir0), .in_insn(insn[0]), .in_pc(pcv[0][31:0]),
      .out_valid(ov0), .out_ready(ordy[0]), .out_type(ty0), .out_imm(imm0),
      .out_target(tgt0), .out_pc(pco0), .out_rd(rd0), .out_rs1(rs10),
      .out_rs2(rs20), .out_opcode(opc0)
   );

   imm_decode_stage #(.XLEN(64), .SKID(0)) dut64 (
      .clk(clk), .rst(rst), .flush(fl[1]),
      .in_valid(iv[1]), .in_ready(ir1), .in_insn(insn[1]), .in_pc(pcv[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .out_type(ty1), .out_imm(imm1),
      .out_target(tgt1), .out_pc(pco1), .out_rd(rd1), .out_rs1(rs11),
      .out_rs2(rs21), .out_opcode(opc1)
   );

   typedef struct {
      logic [2:0]  ty;
      logic [63:0] imm, tgt, pc;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opc;
   } exp_t;

   typedef struct {
      logic        v, r;
      logic [2:0]  ty;
      logic [63:0] imm, tgt, pc;
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  opc;
   } obs_t;

   typedef struct {
      logic [31:0] insn;
      logic [63:0] pc;
      bit          x64;
      logic [2:0]  ty;
      logic [63:0] imm, tgt;
      logic [4:0]  rd;
   } vec_t;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   exp_t        mq[2][$];
   vec_t        vt[13];
   logic [6:0]  opcs[13];

   // Reference decode from the format rules, using signed arithmetic.
   function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc, input bit x64);
      exp_t        e;
      longint      s;
      logic [63:0] mask;
      mask = x64 ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h0f, 7'h73: e.ty = 3'd0;
         7'h23:        e.ty = 3'd1;
         7'h63:        e.ty = 3'd2;
         7'h37, 7'h17: e.ty = 3'd3;
         7'h6f:        e.ty = 3'd4;
         7'h33:        e.ty = 3'd5;
         7'h3b:        e.ty = x64 ? 3'd5 : 3'd7;
         7'h1b:        e.ty = x64 ? 3'd0 : 3'd7;
         default:      e.ty = 3'd7;
      endcase
      case (e.ty)
         3'd0:    s = longint'($signed(i[31:20]));
         3'd1:    s = longint'($signed({i[31:25], i[11:7]}));
         3'd2:    s = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         3'd3:    s = longint'($signed(i[31:12])) * 64'sd4096;
         3'd4:    s = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         default: s = 0;
      endcase
      e.imm = s & mask;
      e.pc  = pc & mask;
      e.tgt = (pc + e.imm) & mask;
      e.rd  = i[11:7];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.opc = i[6:0];
      return e;
   endfunction

   function automatic obs_t observe(input int d);
      obs_t o;
      if (d == 0) begin
         o.v = ov0; o.r = ir0; o.ty = ty0;
         o.imm = 64'(imm0); o.tgt = 64'(tgt0); o.pc = 64'(pco0);
         o.rd = rd0; o.rs1 = rs10; o.rs2 = rs20; o.opc = opc0;
      end else begin
         o.v = ov1; o.r = ir1; o.ty = ty1;
         o.imm = imm1; o.tgt = tgt1; o.pc = pco1;
         o.rd = rd1; o.rs1 = rs11; o.rs2 = rs21; o.opc = opc1;
      end
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_beat(input int d, input exp_t e, input string nm);
      obs_t o;
      o = observe(d);
      chk({nm, ".valid"},  64'(o.v), 64'd1);
      chk({nm, ".type"},   64'(o.ty), 64'(e.ty));
      chk({nm, ".imm"},    o.imm, e.imm);
      chk({nm, ".target"}, o.tgt, e.tgt);
      chk({nm, ".pc"},     o.pc, e.pc);
      chk({nm, ".rd"},     64'(o.rd), 64'(e.rd));
      chk({nm, ".rs1"},    64'(o.rs1), 64'(e.rs1));
      chk({nm, ".rs2"},    64'(o.rs2), 64'(e.rs2));
      chk({nm, ".opcode"}, 64'(o.opc), 64'(e.opc));
   endtask

   task automatic chk_vr(input int d, input bit v, input bit r, input string nm);
      obs_t o;
      o = observe(d);
      chk({nm, ".valid"}, 64'(o.v), 64'(v));
      chk({nm, ".ready"}, 64'(o.r), 64'(r));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string nm);
      obs_t o;
      for (int d = 0; d < 2; d++) begin
         o = observe(d);
         chk($sformatf("%s%0d.valid", nm, d), 64'(o.v), 64'd0);
         chk($sformatf("%s%0d.ready", nm, d), 64'(o.r), 64'd1);
         chk($sformatf("%s%0d.type", nm, d), 64'(o.ty), 64'd0);
         chk($sformatf("%s%0d.imm", nm, d), o.imm, 64'd0);
         chk($sformatf("%s%0d.target", nm, d), o.tgt, 64'd0);
         chk($sformatf("%s%0d.pc", nm, d), o.pc, 64'd0);
         chk($sformatf("%s%0d.rd", nm, d), 64'(o.rd), 64'd0);
      end
   endtask

   initial begin
      exp_t        e;
      exp_t        b[3];
      logic [31:0] bi[3];
      logic [63:0] bp[3];
      int          d;
      bit          rdy, push, pop;
      obs_t        o;

      vt[0]  = '{32'hfff00013, 64'h0,         1'b0, 3'd0, 64'hffffffff,          64'hffffffff,          5'd0};
      vt[1]  = '{32'hfe000f63, 64'h1000,      1'b0, 3'd2, 64'hfffff7fe,          64'h000007fe,          5'd30};
      vt[2]  = '{32'hffdff06f, 64'h100,       1'b0, 3'd4, 64'hfffffffc,          64'h000000fc,          5'd0};
      vt[3]  = '{32'h80000037, 64'h0,         1'b1, 3'd3, 64'hffffffff80000000,  64'hffffffff80000000,  5'd0};
      vt[4]  = '{32'h00000000, 64'h40,        1'b1, 3'd7, 64'h0,                 64'h40,                5'd0};
      vt[5]  = '{32'h00000000, 64'h2000,      1'b0, 3'd7, 64'h0,                 64'h2000,              5'd0};
      vt[6]  = '{32'hfe512e23, 64'h10,        1'b0, 3'd1, 64'hfffffffc,          64'hc,                 5'd28};
      vt[7]  = '{32'h00b5053b, 64'h8,         1'b1, 3'd5, 64'h0,                 64'h8,                 5'd10};
      vt[8]  = '{32'h00b5053b, 64'h8,         1'b0, 3'd7, 64'h0,                 64'h8,                 5'd10};
      vt[9]  = '{32'hfff5051b, 64'h100,       1'b1, 3'd0, 64'hffffffffffffffff,  64'hff,                5'd10};
      vt[10] = '{32'h00000010, 64'h30,        1'b0, 3'd7, 64'h0,                 64'h30,                5'd0};
      vt[11] = '{32'h12345097, 64'h1000,      1'b1, 3'd3, 64'h12345000,          64'h12346000,          5'd1};
      vt[12] = '{32'hffdff06f, 64'h100000000, 1'b1, 3'd4, 64'hfffffffffffffffc,  64'h00000000fffffffc,  5'd0};

      opcs = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
               7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73};

      for (int k = 0; k < 2; k++) begin
         iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1; insn[k] = '0; pcv[k] = '0;
      end

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("rst");
      rst = 1'b0;
      tick();

      // Directed vectors, one beat at a time with out_ready high
      for (int k = 0; k < 13; k++) begin
         d = vt[k].x64 ? 1 : 0;
         iv[d] = 1'b1; insn[d] = vt[k].insn; pcv[d] = vt[k].pc;
         tick();
         iv[d] = 1'b0;
         o = observe(d);
         chk($sformatf("vec%0d.valid", k),  64'(o.v), 64'd1);
         chk($sformatf("vec%0d.type", k),   64'(o.ty), 64'(vt[k].ty));
         chk($sformatf("vec%0d.imm", k),    o.imm, vt[k].imm);
         chk($sformatf("vec%0d.target", k), o.tgt, vt[k].tgt);
         chk($sformatf("vec%0d.rd", k),     64'(o.rd), 64'(vt[k].rd));
         chk_beat(d, model(vt[k].insn, vt[k].pc, vt[k].x64), $sformatf("vecm%0d", k));
         tick();
         chk_vr(d, 1'b0, 1'b1, $sformatf("vec%0d.drain", k));
      end

      // Backpressure on the skid instance: three back-to-back beats
      bi = '{32'h00a00093, 32'hfe512e23, 32'h0040006f};
      bp = '{64'h200, 64'h204, 64'h208};
      for (int k = 0; k < 3; k++) b[k] = model(bi[k], bp[k], 1'b0);
      ordy[0] = 1'b0;
      iv[0] = 1'b1; insn[0] = bi[0]; pcv[0] = bp[0];
      tick(); chk_beat(0, b[0], "bp1"); chk_vr(0, 1'b1, 1'b1, "bp1");
      insn[0] = bi[1]; pcv[0] = bp[1];
      tick(); chk_beat(0, b[0], "bp2"); chk_vr(0, 1'b1, 1'b0, "bp2");
      insn[0] = bi[2]; pcv[0] = bp[2];
      tick(); chk_beat(0, b[0], "bp3"); chk_vr(0, 1'b1, 1'b0, "bp3");
      tick(); chk_beat(0, b[0], "bp4"); chk_vr(0, 1'b1, 1'b0, "bp4");
      ordy[0] = 1'b1;
      tick(); chk_beat(0, b[1], "bp5"); chk_vr(0, 1'b1, 1'b1, "bp5");
      tick(); chk_beat(0, b[2], "bp6");
      iv[0] = 1'b0;
      tick(); chk_vr(0, 1'b0, 1'b1, "bp7");

      // Flush with two entries held and a beat presented
      ordy[0] = 1'b0;
      iv[0] = 1'b1; insn[0] = bi[0]; pcv[0] = bp[0]; tick();
      insn[0] = bi[1]; pcv[0] = bp[1]; tick();
      chk_vr(0, 1'b1, 1'b0, "fl_full");
      fl[0] = 1'b1; insn[0] = bi[2]; pcv[0] = bp[2];
      tick(); chk_vr(0, 1'b0, 1'b1, "fl_two");
      fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); chk_vr(0, 1'b0, 1'b1, $sformatf("fl_two_after%0d", k));
      end
      // Flush in ONE while in_ready is high: the offered beat is dropped
      for (int k = 0; k < 2; k++) begin
         ordy[k] = 1'b0;
         iv[k] = 1'b1; insn[k] = bi[0]; pcv[k] = bp[0]; tick();
         fl[k] = 1'b1; insn[k] = bi[1]; pcv[k] = bp[1];
         tick(); chk_vr(k, 1'b0, 1'b1, $sformatf("fl_one%0d", k));
         fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b1;
         tick(); chk_vr(k, 1'b0, 1'b1, $sformatf("fl_one_after%0d", k));
      end

      // Asynchronous reset mid-stream
      ordy[0] = 1'b0; ordy[1] = 1'b0;
      iv[0] = 1'b1; insn[0] = bi[0]; pcv[0] = bp[0];
      iv[1] = 1'b1; insn[1] = 32'h80000037; pcv[1] = 64'h1234;
      tick();
      insn[0] = bi[1]; pcv[0] = bp[1];
      tick();
      iv[0] = 1'b0; iv[1] = 1'b0;
      chk_vr(0, 1'b1, 1'b0, "arst_pre");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_state("arst");
      tick();
      rst = 1'b0;
      ordy[0] = 1'b1; ordy[1] = 1'b1;
      tick();
      chk_vr(0, 1'b0, 1'b1, "arst_post0");
      chk_vr(1, 1'b0, 1'b1, "arst_post1");

      // Random traffic against the queue model
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < 2; k++) begin
            rdy = (k == 0) ? (mq[k].size() < 2) : (mq[k].size() == 0 || ordy[k]);
            chk_vr(k, mq[k].size() != 0, rdy, $sformatf("rnd%0d.c%0d", k, cyc));
            if (mq[k].size() != 0) chk_beat(k, mq[k][0], $sformatf("rnd%0d.c%0d", k, cyc));
            iv[k]   = ($urandom_range(0, 3) != 0);
            ordy[k] = ($urandom_range(0, 2) != 0);
            fl[k]   = ($urandom_range(0, 19) == 0);
            insn[k] = $urandom;
            if ($urandom_range(0, 7) != 0) insn[k][6:0] = opcs[$urandom_range(0, 12)];
            pcv[k]  = {$urandom, $urandom};
            rdy  = (k == 0) ? (mq[k].size() < 2) : (mq[k].size() == 0 || ordy[k]);
            push = iv[k] && rdy && !fl[k];
            pop  = (mq[k].size() != 0) && ordy[k];
            if (fl[k]) begin
               mq[k].delete();
            end else begin
               if (pop) void'(mq[k].pop_front());
               if (push) begin
                  e = model(insn[k], pcv[k], k == 1);
                  mq[k].push_back(e);
               end
            end
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
